// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads the register file, resolves operands (x0 = 0) and stalls RAW/WAW hazards
// against a 32-entry pending-write scoreboard.
// Latency: 1 cycle from accept to out_valid; full throughput when there are no hazards and out_ready is high.
// Backpressure: in_ready drops on a hazard, or when the output register is full and out_ready is low.
// Build option OPERAND_FETCH_BYPASS_EN: forward same-cycle writeback data instead of waiting a cycle.
module operand_fetch_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic                  in_rs1_used,
    input  logic                  in_rs2_used,
    input  logic                  in_rd_we,
    output logic [ADDR_WIDTH-1:0] rf_read_addr1,
    input  logic [DATA_WIDTH-1:0] rf_read_data1,
    output logic [ADDR_WIDTH-1:0] rf_read_addr2,
    input  logic [DATA_WIDTH-1:0] rf_read_data2,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [DATA_WIDTH-1:0] out_rs1_data,
    output logic [DATA_WIDTH-1:0] out_rs2_data,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_rd_we
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Register fields of the raw instruction
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;

    assign rs1 = in_instr[15 +: ADDR_WIDTH];
    assign rs2 = in_instr[20 +: ADDR_WIDTH];
    assign rd  = in_instr[7  +: ADDR_WIDTH];

    // Register file ports follow the decoded fields every cycle
    assign rf_read_addr1 = rs1;
    assign rf_read_addr2 = rs2;

    // One bit per register: a write to it is still in flight downstream
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    // Writeback forwarding terms; with forwarding off a pending register
    // simply waits until the cycle after its writeback.
    logic byp1;
    logic byp2;
    logic wb_hits_rd;

`ifdef OPERAND_FETCH_BYPASS_EN
    assign byp1       = wb_valid && (wb_addr == rs1) && (rs1 != '0);
    assign byp2       = wb_valid && (wb_addr == rs2) && (rs2 != '0);
    assign wb_hits_rd = wb_valid && (wb_addr == rd);
`else
    assign byp1       = 1'b0;
    assign byp2       = 1'b0;
    assign wb_hits_rd = 1'b0;
`endif

    logic raw_hazard;
    logic waw_hazard;
    logic accept;
    logic rd_we_eff;

    // A source still waiting on its producer, or a second write to a
    // register already in flight, holds the instruction in decode.
    assign raw_hazard = (in_rs1_used && pending[rs1] && !byp1) ||
                        (in_rs2_used && pending[rs2] && !byp2);
    assign waw_hazard = in_rd_we && (rd != '0) && pending[rd] && !wb_hits_rd;

    assign in_ready  = !(raw_hazard || waw_hazard) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign rd_we_eff = in_rd_we && (rd != '0);

    // Operand resolve: x0 reads zero, else forwarded writeback, else register file
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    // Source 1 operand select
    always_comb begin
        rs1_data = '0;
        if (rs1 != '0) begin
            rs1_data = byp1 ? wb_data : rf_read_data1;
        end
    end

    // Source 2 operand select
    always_comb begin
        rs2_data = '0;
        if (rs2 != '0) begin
            rs2_data = byp2 ? wb_data : rf_read_data2;
        end
    end

    // Scoreboard next state: writeback clears first so a same-cycle issue to
    // the same register leaves it pending; entry 0 never becomes pending.
    always_comb begin
        pending_nxt = pending;
        if (wb_valid) begin
            pending_nxt[wb_addr] = 1'b0;
        end
        if (accept && rd_we_eff) begin
            pending_nxt[rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // One-entry output register: load on accept, drain when execute takes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_instr    <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rd       <= '0;
            out_rd_we    <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_instr    <= in_instr;
            out_rs1_data <= rs1_data;
            out_rs2_data <= rs2_data;
            out_rd       <= rd;
            out_rd_we    <= rd_we_eff;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule
